// File: rtl/ro_edge_counter.sv
// Ring-oscillator edge counter: enables the oscillator, lets it settle, then counts
// synchronized rising edges over a fixed window and reports the count with a done pulse.
module ro_edge_counter #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned WINDOW_CYCLES = 1024,
    parameter int unsigned COUNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   ro_in,
    output logic                   ro_enable,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   overflow
);

    localparam int unsigned MAX_CYC = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES
                                                                      : WINDOW_CYCLES;
    localparam int unsigned CYC_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

    localparam logic [CYC_W-1:0]       SETTLE_LOAD = CYC_W'(SETTLE_CYCLES - 1);
    localparam logic [CYC_W-1:0]       WINDOW_LOAD = CYC_W'(WINDOW_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] EDGE_MAX    = '1;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StMeasure,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [2:0]             sync_q, sync_d;
    logic [CYC_W-1:0]       cyc_q, cyc_d;
    logic [COUNT_WIDTH-1:0] edge_q, edge_d;
    logic                   sat_q, sat_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic                   rise;

    // sync_q[1:0] is the 2-FF synchronizer, sync_q[2] the delayed copy for edge detection.
    assign sync_d = {sync_q[1:0], ro_in};
    assign rise   = sync_q[1] & ~sync_q[2];

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        edge_d  = edge_q;
        sat_d   = sat_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSettle;
                    cyc_d   = SETTLE_LOAD;
                    edge_d  = '0;
                    sat_d   = 1'b0;
                end
            end
            StSettle: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (cyc_q == '0) begin
                    state_d = StMeasure;
                    cyc_d   = WINDOW_LOAD;
                end else begin
                    cyc_d = cyc_q - CYC_W'(1);
                end
            end
            StMeasure: begin
                if (rise) begin
                    if (edge_q == EDGE_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        edge_d = edge_q + COUNT_WIDTH'(1);
                    end
                end
                if (abort) begin
                    state_d = StIdle;
                end else if (cyc_q == '0) begin
                    // Latch on entry to DONE so the result is valid alongside the done pulse.
                    state_d = StDone;
                    count_d = edge_d;
                    ovf_d   = sat_d;
                end else begin
                    cyc_d = cyc_q - CYC_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sync_q  <= '0;
            cyc_q   <= '0;
            edge_q  <= '0;
            sat_q   <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cyc_q   <= cyc_d;
            edge_q  <= edge_d;
            sat_q   <= sat_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ro_enable = (state_q == StSettle) || (state_q == StMeasure);
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign count     = count_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_ro_edge_counter.sv
// Bench for ro_edge_counter: two instances (wide counter and saturating 4-bit counter)
// checked every cycle against a timeline model, plus hand-computed expectations.
module tb_ro_edge_counter;

    localparam int unsigned SA = 4, WA = 64,  CA = 16;
    localparam int unsigned SB = 4, WB = 100, CB = 4;
    localparam int unsigned PS[2]   = '{SA, SB};
    localparam int unsigned PW[2]   = '{WA, WB};
    localparam int unsigned PMAX[2] = '{(1 << CA) - 1, (1 << CB) - 1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0, abort_a = 1'b0, ro_a = 1'b0;
    logic start_b = 1'b0, abort_b = 1'b0, ro_b = 1'b0;
    logic en_a, busy_a, done_a, ovf_a;
    logic en_b, busy_b, done_b, ovf_b;
    logic [CA-1:0] count_a;
    logic [CB-1:0] count_b;

    int checks = 0;
    int errors = 0;

    ro_edge_counter #(.SETTLE_CYCLES(SA), .WINDOW_CYCLES(WA), .COUNT_WIDTH(CA)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .ro_in(ro_a),
        .ro_enable(en_a), .busy(busy_a), .done(done_a), .count(count_a), .overflow(ovf_a)
    );

    ro_edge_counter #(.SETTLE_CYCLES(SB), .WINDOW_CYCLES(WB), .COUNT_WIDTH(CB)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .ro_in(ro_b),
        .ro_enable(en_b), .busy(busy_b), .done(done_b), .count(count_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Oscillator waveforms: 0 = low, 1 = high, 2 = period 8 clk, 3 = period 4 clk.
    int mode_a = 2, mode_b = 3, tick = 0;

    function automatic logic wave(input int mode, input int t);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (t % 8) < 4;
            default: return (t % 4) < 2;
        endcase
    endfunction

    always @(posedge clk) begin
        #2;
        tick++;
        ro_a = wave(mode_a, tick);
        ro_b = wave(mode_b, tick);
    end

    // Model: k is the index of the clock interval since the start edge (0..S-1 settle,
    // S..S+W-1 measure, S+W done). An edge counts when the ro samples taken two and three
    // edges back show 0 -> 1 during a measure interval.
    bit          m_active[2];
    int unsigned m_k[2];
    int unsigned m_edges[2];
    bit          m_p1[2], m_p2[2], m_p3[2];
    int unsigned m_cnt[2];
    bit          m_ovf[2];

    task automatic model_step(input int i, input logic st, input logic ab, input logic ro);
        bit rise;
        rise = m_p2[i] & ~m_p3[i];
        if (!m_active[i]) begin
            if (st) begin
                m_active[i] = 1'b1;
                m_k[i]      = 0;
                m_edges[i]  = 0;
            end
        end else if (m_k[i] < PS[i]) begin
            if (ab) m_active[i] = 1'b0;
            else m_k[i]++;
        end else if (m_k[i] < PS[i] + PW[i]) begin
            if (rise) m_edges[i]++;
            if (ab) begin
                m_active[i] = 1'b0;
            end else begin
                if (m_k[i] == PS[i] + PW[i] - 1) begin
                    m_cnt[i] = (m_edges[i] > PMAX[i]) ? PMAX[i] : m_edges[i];
                    m_ovf[i] = (m_edges[i] > PMAX[i]);
                end
                m_k[i]++;
            end
        end else begin
            m_active[i] = 1'b0;
        end
        m_p3[i] = m_p2[i];
        m_p2[i] = m_p1[i];
        m_p1[i] = ro;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_active[i] = 1'b0; m_k[i] = 0; m_edges[i] = 0;
                m_p1[i] = 1'b0; m_p2[i] = 1'b0; m_p3[i] = 1'b0;
                m_cnt[i] = 0; m_ovf[i] = 1'b0;
            end
        end else begin
            model_step(0, start_a, abort_a, ro_a);
            model_step(1, start_b, abort_b, ro_b);
        end
    end

    function automatic logic exp_en(input int i);
        return m_active[i] && (m_k[i] < PS[i] + PW[i]);
    endfunction

    function automatic logic exp_done(input int i);
        return m_active[i] && (m_k[i] == PS[i] + PW[i]);
    endfunction

    int en_cnt_a = 0, done_cnt_a = 0;

    always @(negedge clk) begin
        check("a.ro_enable", 32'(en_a), 32'(exp_en(0)));
        check("a.busy", 32'(busy_a), 32'(m_active[0]));
        check("a.done", 32'(done_a), 32'(exp_done(0)));
        check("a.count", 32'(count_a), m_cnt[0]);
        check("a.overflow", 32'(ovf_a), 32'(m_ovf[0]));
        check("b.ro_enable", 32'(en_b), 32'(exp_en(1)));
        check("b.busy", 32'(busy_b), 32'(m_active[1]));
        check("b.done", 32'(done_b), 32'(exp_done(1)));
        check("b.count", 32'(count_b), m_cnt[1]);
        check("b.overflow", 32'(ovf_b), 32'(m_ovf[1]));
        if (en_a) en_cnt_a++;
        if (done_a) done_cnt_a++;
    end

    task automatic pulse(input int i);
        @(posedge clk);
        #2;
        if (i == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk);
        #2;
        if (i == 0) start_a = 1'b0; else start_b = 1'b0;
    endtask

    // Returns the interval index (since the start edge) in which done is seen.
    task automatic wait_done(input int i, output int lat);
        lat = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            lat++;
            if ((i == 0) ? done_a : done_b) return;
        end
        check("done_timeout", 32'(lat), 32'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".a.en"}, 32'(en_a), 0);
        check({tag, ".a.busy"}, 32'(busy_a), 0);
        check({tag, ".a.done"}, 32'(done_a), 0);
        check({tag, ".a.count"}, 32'(count_a), 0);
        check({tag, ".a.ovf"}, 32'(ovf_a), 0);
        check({tag, ".b.en"}, 32'(en_b), 0);
        check({tag, ".b.count"}, 32'(count_b), 0);
    endtask

    initial begin
        int lat;
        int en_base, done_base;

        // Reset with the oscillators toggling.
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1 check_all_zero("idle_after_reset");

        // Period-8 oscillator: 8 edges in a 64-cycle window.
        en_base = en_cnt_a;
        pulse(0);
        wait_done(0, lat);
        check("p8.done_cycle", 32'(lat), 32'(69));
        check("p8.count", 32'(count_a), 32'(8));
        check("p8.overflow", 32'(ovf_a), 32'(0));
        check("p8.enable_cycles", 32'(en_cnt_a - en_base), 32'(68));

        // Oscillator stuck high: no edges.
        mode_a = 1;
        repeat (6) @(posedge clk);
        pulse(0);
        wait_done(0, lat);
        check("hi.done_cycle", 32'(lat), 32'(69));
        check("hi.count", 32'(count_a), 32'(0));

        // 4-bit counter, period 4 over 100 cycles: 25 edges saturate at 15.
        pulse(1);
        wait_done(1, lat);
        check("sat.done_cycle", 32'(lat), 32'(105));
        check("sat.count", 32'(count_b), 32'(15));
        check("sat.overflow", 32'(ovf_b), 32'(1));
        mode_b = 0;
        repeat (6) @(posedge clk);
        pulse(1);
        wait_done(1, lat);
        check("lo.count", 32'(count_b), 32'(0));
        check("lo.overflow", 32'(ovf_b), 32'(0));

        // Start re-pulsed during MEASURE is ignored.
        mode_a = 2;
        repeat (6) @(posedge clk);
        done_base = done_cnt_a;
        pulse(0);
        repeat (30) @(posedge clk);
        pulse(0);
        wait_done(0, lat);
        repeat (80) @(posedge clk);
        check("restart.done_pulses", 32'(done_cnt_a - done_base), 32'(1));
        check("restart.count", 32'(count_a), 32'(8));

        // Abort during MEASURE.
        done_base = done_cnt_a;
        pulse(0);
        repeat (30) @(posedge clk);
        #2 abort_a = 1'b1;
        @(posedge clk);
        #2 abort_a = 1'b0;
        @(negedge clk);
        check("abort.ro_enable", 32'(en_a), 32'(0));
        check("abort.busy", 32'(busy_a), 32'(0));
        repeat (100) @(posedge clk);
        check("abort.done_pulses", 32'(done_cnt_a - done_base), 32'(0));
        check("abort.count", 32'(count_a), 32'(8));

        // Asynchronous reset mid-MEASURE, then a fresh measurement.
        pulse(0);
        repeat (40) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("midreset");
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (4) @(posedge clk);
        pulse(0);
        wait_done(0, lat);
        check("fresh.done_cycle", 32'(lat), 32'(69));
        check("fresh.count", 32'(count_a), 32'(8));
        check("fresh.overflow", 32'(ovf_a), 32'(0));

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
